// File: rtl/imem_load_ctrl.sv
// Boot-load and access controller for the word-addressed instruction memory.
// After reset it holds the core stalled, streams program words from the loader
// (valid/ready) into the memory write port, then releases the core and checks
// every fetch PC for alignment and against the loaded program length.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   ld_valid_i        loader word valid
//   ld_ready_o        controller accepts a loader word (registered)
//   ld_data_i         instruction word from loader
//   ld_last_i         marks ld_data_i as the final program word
//   reload_req_i      single-cycle request to reload the program
//   fetch_pc_i        byte PC from the fetch stage
//   mem_we_o          instruction memory write enable
//   mem_waddr_o       memory write word address
//   mem_wdata_o       memory write data
//   mem_raddr_o       memory read word address (fetch_pc_i >> 2), combinational
//   core_run_o        pipeline may advance; 0 stalls the core
//   fetch_fault_o     sticky illegal-fetch flag
//   words_loaded_o    number of valid program words
module imem_load_ctrl #(
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  input  logic              reload_req_i,
  input  logic [31:0]       fetch_pc_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic              core_run_o,
  output logic              fetch_fault_o,
  output logic [CNT_W-1:0]  words_loaded_o
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ld_ready_q, ld_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                fault_q, fault_d;
  // Word count doubles as the write pointer: the next word lands at index cnt_q.
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                xfer;
  logic                illegal_fetch;

  assign xfer          = ld_valid_i & ld_ready_q;
  assign illegal_fetch = (fetch_pc_i[1:0] != 2'b00) ||
                         (fetch_pc_i[31:2] >= 30'(cnt_q));

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ld_ready_d = ld_ready_q;
    mem_we_d   = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    run_d      = run_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;

    if (state_q == ST_LOAD) begin
      ld_ready_d = 1'b1;
      if (xfer) begin
        mem_we_d = 1'b1;
        waddr_d  = cnt_q[ADDR_W-1:0];
        wdata_d  = ld_data_i;
        cnt_d    = cnt_q + CNT_W'(1);
        // Stop on the marked last word or when the memory is full.
        if (ld_last_i || (cnt_q == CNT_W'(DEPTH - 1))) begin
          state_d    = ST_COMMIT;
          ld_ready_d = 1'b0;
        end
      end
    end else if (reload_req_i) begin
      // Reload beats any fault check; ready rises one edge after re-entering LOAD.
      state_d    = ST_LOAD;
      ld_ready_d = 1'b0;
      run_d      = 1'b0;
      fault_d    = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_COMMIT: begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
        ST_RUN: begin
          if (illegal_fetch) begin
            state_d = ST_FAULT;
            run_d   = 1'b0;
            fault_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      ld_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      mem_we_q   <= mem_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ld_ready_o     = ld_ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_waddr_o    = waddr_q;
  assign mem_wdata_o    = wdata_q;
  assign core_run_o     = run_q;
  assign fetch_fault_o  = fault_q;
  assign words_loaded_o = cnt_q;
  assign mem_raddr_o    = fetch_pc_i[ADDR_W+1:2];

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_imem_load_ctrl;

  localparam int unsigned DEPTH  = 20;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 6;

  localparam int P_LOAD   = 0;
  localparam int P_COMMIT = 1;
  localparam int P_RUN    = 2;
  localparam int P_FAULT  = 3;

  logic              clk;
  logic              rst_n;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              reload_req;
  logic [31:0]       fetch_pc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic              core_run;
  logic              fetch_fault;
  logic [CNT_W-1:0]  words_loaded;

  imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_data_i     (ld_data),
    .ld_last_i     (ld_last),
    .reload_req_i  (reload_req),
    .fetch_pc_i    (fetch_pc),
    .mem_we_o      (mem_we),
    .mem_waddr_o   (mem_waddr),
    .mem_wdata_o   (mem_wdata),
    .mem_raddr_o   (mem_raddr),
    .core_run_o    (core_run),
    .fetch_fault_o (fetch_fault),
    .words_loaded_o(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what each registered output should show this cycle.
  int          m_phase;
  bit          m_ready, m_we, m_run, m_fault;
  int          m_waddr, m_words;
  logic [31:0] m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_LOAD; m_ready = 0; m_we = 0; m_run = 0; m_fault = 0;
    m_waddr = 0; m_words = 0; m_wdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_step();
    int ph, wa, wl;
    bit rdy, we, run, flt;
    logic [31:0] wd;
    ph = m_phase; rdy = m_ready; we = 0; run = m_run; flt = m_fault;
    wa = m_waddr; wd = m_wdata; wl = m_words;
    if (m_phase == P_LOAD) begin
      rdy = 1;
      if (m_ready && ld_valid) begin
        we = 1; wa = m_words; wd = ld_data; wl = m_words + 1;
        if (ld_last || wl == DEPTH) begin ph = P_COMMIT; rdy = 0; end
      end
    end else if (reload_req) begin
      ph = P_LOAD; rdy = 0; run = 0; flt = 0; wl = 0;
    end else if (m_phase == P_COMMIT) begin
      ph = P_RUN; run = 1;
    end else if (m_phase == P_RUN &&
                 (fetch_pc[1:0] != 2'b00 || (fetch_pc >> 2) >= 32'(m_words))) begin
      ph = P_FAULT; run = 0; flt = 1;
    end
    m_phase = ph; m_ready = rdy; m_we = we; m_run = run; m_fault = flt;
    m_waddr = wa; m_wdata = wd; m_words = wl;
  endtask

  task automatic check_all();
    chk("ld_ready", 32'(ld_ready), 32'(m_ready));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_waddr", 32'(mem_waddr), 32'(m_waddr));
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("core_run", 32'(core_run), 32'(m_run));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    chk("words_loaded", 32'(words_loaded), 32'(m_words));
    chk("mem_raddr", 32'(mem_raddr), (fetch_pc >> 2) & 32'h1F);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit last,
                       input bit rl, input logic [31:0] pc);
    ld_valid = v; ld_data = d; ld_last = last; reload_req = rl; fetch_pc = pc;
  endtask

  task automatic idle(input int n, input logic [31:0] pc);
    drive(0, 32'hDEAD_BEEF, 0, 0, pc);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reload();
    drive(0, 32'h0, 0, 1, 32'h0);
    step();
    drive(0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093; prog[2] = 32'h0000_8067;
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0);
    model_reset();
    do_reset();

    // Three-word program with ld_valid held high
    idle(1, 32'h0);
    chk("t1_ready_up", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1, prog[i], i == 2, 0, 32'h0);
      step();
    end
    chk("t1_last_we", 32'(mem_we), 32'd1);
    chk("t1_last_addr", 32'(mem_waddr), 32'd2);
    chk("t1_ready_low", 32'(ld_ready), 32'd0);
    drive(1, 32'h1234_5678, 0, 0, 32'h8);
    step();
    chk("t1_run", 32'(core_run), 32'd1);
    chk("t1_words", 32'(words_loaded), 32'd3);
    idle(3, 32'h8);
    chk("t4_no_fault", 32'(fetch_fault), 32'd0);

    // PC one past the program faults
    idle(2, 32'hC);
    chk("t4_fault", 32'(fetch_fault), 32'd1);
    chk("t4_stall", 32'(core_run), 32'd0);

    // Reload from FAULT with a two-word program
    reload();
    chk("t5_fault_clr", 32'(fetch_fault), 32'd0);
    chk("t5_words_clr", 32'(words_loaded), 32'd0);
    chk("t5_ready_wait", 32'(ld_ready), 32'd0);
    idle(1, 32'h0);
    chk("t5_ready_up", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'hA000_0000 + 32'(i), i == 1, 0, 32'h4);
      step();
    end
    idle(3, 32'h4);
    chk("t5_words", 32'(words_loaded), 32'd2);
    chk("t5_run", 32'(core_run), 32'd1);

    // Misaligned PC faults
    idle(2, 32'h6);
    chk("t4_misalign", 32'(fetch_fault), 32'd1);

    // Overlong stream is cut at DEPTH words
    reload();
    idle(1, 32'h0);
    for (int i = 0; i < 25; i++) begin
      drive(1, 32'hB000_0000 + 32'(i), 0, 0, 32'h0);
      step();
    end
    idle(2, 32'h0);
    chk("t2_words", 32'(words_loaded), 32'(DEPTH));
    chk("t2_run", 32'(core_run), 32'd1);
    idle(2, 32'(DEPTH * 4 - 4));
    chk("t2_top_legal", 32'(fetch_fault), 32'd0);

    // Valid with gaps: 1,0,0,1 pattern
    reload();
    idle(1, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive((i % 4 == 0) || (i % 4 == 3), 32'hC000_0000 + 32'(i), i == 15, 0, 32'h0);
      step();
    end
    idle(3, 32'h0);
    chk("t3_words", 32'(words_loaded), 32'd8);

    // Reset in the middle of a load, then a fresh four-word load
    reload();
    idle(1, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'hD000_0000 + 32'(i), 0, 0, 32'h0);
      step();
    end
    do_reset();
    idle(1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hE000_0000 + 32'(i), i == 3, 0, 32'h0);
      step();
      if (i == 0) chk("t6_addr0", 32'(mem_waddr), 32'd0);
    end
    idle(2, 32'hC);
    chk("t6_words", 32'(words_loaded), 32'd4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      if ($urandom_range(0, 9) < 7) begin
        pc = 32'($urandom_range(0, (m_words > 0) ? m_words - 1 : 0)) << 2;
      end else begin
        pc = $urandom & 32'h7F;
      end
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 24) == 0, pc);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Boot-load and access controller for the core's word-addressed instruction memory. After reset it holds the pipeline out of execution and streams program words from a loader port into the memory over a valid/ready handshake. It then releases the core and checks every fetch PC against alignment and the loaded program length. The block sits between the boot/debug loader, the instruction memory write port, and the fetch stage.

Parameters:
DEPTH, 20, instruction memory depth in 32-bit words
ADDR_W, 5, word-address width; 2^ADDR_W >= DEPTH
CNT_W, 6, width of word counters; 2^CNT_W > DEPTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ld_valid  input  1  loader word valid
ld_ready  output  1  controller accepts a loader word
ld_data  input  32  instruction word from loader
ld_last  input  1  qualifies ld_data as final program word
reload_req  input  1  single-cycle request to reload the program
fetch_PC  input  32  byte PC from fetch stage
mem_we  output  1  instruction memory write enable
mem_waddr  output  ADDR_W  memory write word address
mem_wdata  output  32  memory write data
mem_raddr  output  ADDR_W  memory read word address (fetch_PC>>2)
core_run  output  1  pipeline may advance; 0 holds the core stalled
fetch_fault  output  1  sticky illegal-fetch flag
words_loaded  output  CNT_W  number of valid program words

Behaviour:
- Reset (async, rst_n=0): state=LOAD, wr_ptr=0. All outputs are 0: ld_ready, mem_we, mem_waddr, mem_wdata, core_run, fetch_fault, words_loaded.
- States: LOAD, COMMIT, RUN, FAULT.
- LOAD:
  - ld_ready=1 from the first clock edge after reset release. ld_ready is registered.
  - A transfer occurs on an edge where ld_valid & ld_ready are both 1.
  - On each transfer, the next cycle shows mem_we=1, mem_waddr=wr_ptr, mem_wdata=ld_data (1-cycle registered latency). wr_ptr and words_loaded each increment by 1.
  - mem_we=0 in every cycle that does not follow a transfer.
  - If the transfer has ld_last=1 or wr_ptr==DEPTH-1: go to COMMIT and deassert ld_ready on the same edge. No word beyond DEPTH is ever accepted.
  - ld_valid=0 simply holds state. ld_data is only sampled on a transfer.
- COMMIT: one cycle in which the final write is visible on mem_we. Then go to RUN.
- RUN:
  - core_run=1, registered, first high in the cycle after the final mem_we pulse. ld_ready=0 and ld_valid is ignored.
  - Illegal fetch: fetch_PC[1:0]!=0, or fetch_PC>>2 >= words_loaded.
  - On an illegal fetch: go to FAULT. On the next edge, core_run=0 and fetch_fault=1.
- FAULT: core_run=0, fetch_fault stays 1, ld_ready=0.
- reload_req:
  - Honoured in RUN, COMMIT and FAULT. Ignored in LOAD.
  - Next edge: state=LOAD, core_run=0, fetch_fault=0, wr_ptr=0, words_loaded=0. ld_ready=1 one edge later.
  - Priority: reload_req wins over an illegal fetch detected in the same cycle.
- mem_raddr = fetch_PC[ADDR_W+1:2], combinational, in all states. It is unused by the core while core_run=0.
- fetch_PC is not checked outside RUN.
- Reset asserted mid-load returns the block to the reset values immediately. Partially written memory contents are not cleared; words_loaded=0 makes them unreachable.
- An empty program cannot occur: ld_last is only meaningful on a transfer, so words_loaded>=1 when entering COMMIT.

Test Plan:
1. Reset release, loader sends 3 words 0x00000013, 0x00100093, 0x00008067 (last on third) with ld_valid constant -> three mem_we pulses at waddr 0,1,2 one cycle after each transfer; words_loaded=3; ld_ready low after 3rd transfer; core_run=1 two cycles after the final transfer.
2. Loader streams 25 words with no ld_last -> exactly 20 writes (waddr 0..19); ld_ready drops after the 20th; words 21-25 never accepted; words_loaded=20.
3. Loader gaps (ld_valid toggling 1,0,0,1) -> writes occur only after valid cycles; no mem_we in gap cycles; addresses contiguous.
4. RUN with words_loaded=3: fetch_PC=0x8 -> no fault; fetch_PC=0xC -> fetch_fault=1, core_run=0 next cycle; fetch_PC=0x6 in a separate run -> fault.
5. In FAULT, pulse reload_req -> next cycle fetch_fault=0, words_loaded=0, state LOAD; ld_ready=1 following cycle; reload of 2 words -> RUN with words_loaded=2.
6. Assert rst_n=0 after 2 of 4 words, then release and load 4 words -> outputs 0 asynchronously during reset; new load writes from waddr 0; words_loaded=4.
